// File: rtl/bech_datapath_resp.sv
// Datapath responder: executes the controller's micro-op strobes on W/C/E/pend/wdog and returns 18 condition flags.
// Latency: an op sampled at edge N is visible on cond after that edge; cond is decoded from registered state only.
// Backpressure: none; ops are consumed every cycle ops_valid=1, and a y34 clears the pending request and pulses done_o.
module bech_datapath_resp #(
   parameter int              DW      = 16,
   parameter int              CW      = 4,
   parameter int              THRESH  = 8,
   parameter int              TIMEOUT = 15,
   parameter logic [DW-1:0]   MASK    = DW'(16'hA5A5)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           ops_valid,
   input  logic [38:0]    ops,
   input  logic           req_i,
   input  logic [DW-1:0]  data_in,
   output logic [17:0]    cond,
   output logic           done_o,
   output logic [7:0]     act_cnt
);

   localparam logic [CW-1:0] C_MAX  = '1;
   localparam logic [7:0]    WD_LIM = 8'(TIMEOUT);

   logic [DW-1:0] w_q, w_d;
   logic [CW-1:0] c_q, c_d;
   logic          e_q, e_d;
   logic          pend_q, pend_d;
   logic [7:0]    wd_q, wd_d;
   logic          done_q, done_d;
   logic [7:0]    act_q, act_d;

   // Strobes are only meaningful when qualified; y39 is a deliberate no-op.
   logic [38:0] y;
   logic        aux_hit;
   logic        unused_y39;
   assign y          = ops_valid ? ops : '0;
   assign aux_hit    = (|y[26:5]) | (|y[32:28]);
   assign unused_y39 = y[38];

   // Next-state decode for every piece of datapath state.
   always_comb begin
      w_d    = w_q;
      c_d    = c_q;
      e_d    = e_q;
      act_d  = act_q;
      wd_d   = wd_q;

      // W: first matching strobe wins.
      if (y[0] || y[34] || y[35]) begin
         w_d = data_in;
      end else if (y[36]) begin
         w_d = ~w_q;
      end else if (y[4]) begin
         w_d = w_q ^ MASK;
      end else if (y[3]) begin
         w_d = {w_q[DW-2:0], 1'b0};
      end

      // C: clear dominates; simultaneous inc/dec cancels; both directions saturate.
      if (y[1] || y[34]) begin
         c_d = '0;
      end else if (y[2] && y[37]) begin
         c_d = c_q;
      end else if (y[2]) begin
         if (c_q != C_MAX) c_d = c_q + CW'(1);
      end else if (y[37]) begin
         if (c_q != '0) c_d = c_q - CW'(1);
      end

      // E: an overflow attempt or y28 sets it, and set beats clear.
      if (y[27] || (y[2] && (c_q == C_MAX))) begin
         e_d = 1'b1;
      end else if (y[1]) begin
         e_d = 1'b0;
      end

      // A valid y34 retires the request, even against a concurrent req_i.
      pend_d = (pend_q | req_i) & ~y[33];
      done_d = y[33];

      // Watchdog counts cycles spent waiting on an already-pending request.
      if (!pend_d) begin
         wd_d = '0;
      end else if (pend_q && (wd_q < WD_LIM)) begin
         wd_d = wd_q + 8'd1;
      end

      if (aux_hit) act_d = act_q + 8'd1;
   end

   // State registers with synchronous active-low reset that overrides any op.
   always_ff @(posedge clk) begin
      if (!rst) begin
         w_q    <= '0;
         c_q    <= '0;
         e_q    <= 1'b0;
         pend_q <= 1'b0;
         wd_q   <= '0;
         done_q <= 1'b0;
         act_q  <= '0;
      end else begin
         w_q    <= w_d;
         c_q    <= c_d;
         e_q    <= e_d;
         pend_q <= pend_d;
         wd_q   <= wd_d;
         done_q <= done_d;
         act_q  <= act_d;
      end
   end

   // Condition flags decoded purely from registered state.
   always_comb begin
      cond      = '0;
      cond[0]   = pend_q;
      cond[1]   = w_q[DW-1];
      cond[2]   = (c_q == '0);
      cond[3]   = w_q[0];
      cond[4]   = w_q[1];
      cond[5]   = ^w_q;
      cond[6]   = w_q[2];
      cond[7]   = w_q[3];
      cond[8]   = w_q[4];
      cond[9]   = (32'(c_q) >= 32'(THRESH));
      cond[10]  = e_q;
      cond[11]  = c_q[0];
      cond[12]  = (w_q == '0);
      cond[13]  = (wd_q == WD_LIM);
      cond[14]  = w_q[5];
      cond[15]  = w_q[6];
      cond[16]  = w_q[7];
      cond[17]  = w_q[8];
   end

   assign done_o  = done_q;
   assign act_cnt = act_q;

endmodule
